// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory-stage controller and the condition checker.
// Holds the controller state encoding, ARM condition codes and NZCV flag positions.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 31;
    localparam int FLAG_Z = 30;
    localparam int FLAG_C = 29;
    localparam int FLAG_V = 28;

endpackage

// File: rtl/cond_check.sv
// ARM condition evaluator: pass=1 when cond is satisfied by the NZCV flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none; a stateless function that is reusable by the branch unit.
module cond_check
    import mem_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic       flag_n,
    input  logic       flag_z,
    input  logic       flag_c,
    input  logic       flag_v,
    output logic       pass
);

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = flag_z;
            COND_NE: pass = ~flag_z;
            COND_CS: pass = flag_c;
            COND_CC: pass = ~flag_c;
            COND_MI: pass = flag_n;
            COND_PL: pass = ~flag_n;
            COND_VS: pass = flag_v;
            COND_VC: pass = ~flag_v;
            COND_HI: pass = flag_c & ~flag_z;
            COND_LS: pass = ~flag_c | flag_z;
            COND_GE: pass = (flag_n == flag_v);
            COND_LT: pass = (flag_n != flag_v);
            COND_GT: pass = ~flag_z & (flag_n == flag_v);
            COND_LE: pass = flag_z | (flag_n != flag_v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage LDR/STR controller: condition gating, req/ack handshake with timeout, writeback of loads.
// Latency: accept in cycle 0, mem_req from cycle 1, RESP one cycle after ack; 3 cycles minimum per op.
// Backpressure: stall held high in the accept cycle and throughout REQ; MEM_ALIGN_CHECK_EN faults misaligned words.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    input  logic                  op_load,
    input  logic                  op_store,
    input  logic                  op_byte,
    input  logic [3:0]            op_cond,
    input  logic [3:0]            op_rd,
    input  logic [31:0]           status_reg,
    input  logic [ADDR_W-1:0]     addr_in,
    input  logic [DATA_W-1:0]     store_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  stall,
    output logic                  wb_valid,
    output logic [3:0]            wb_rd,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  fault
);

    localparam int BE_W   = DATA_W / 8;
    localparam int LANE_W = (BE_W > 1) ? $clog2(BE_W) : 1;
    localparam int CNT_W  = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(BE_W - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_WAIT - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic                we_q, we_d;
    logic                load_q, load_d;
    logic                byte_q, byte_d;
    logic [3:0]          rd_q, rd_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                fault_q, fault_d;

    logic                cond_pass;
    logic                accept;
    logic [LANE_W-1:0]   lane_in, lane_q;
    logic [7:0]          byte_sel;
    logic                unused_status;

    assign unused_status = ^status_reg[27:0];

    cond_check u_cond_check (
        .cond   (op_cond),
        .flag_n (status_reg[FLAG_N]),
        .flag_z (status_reg[FLAG_Z]),
        .flag_c (status_reg[FLAG_C]),
        .flag_v (status_reg[FLAG_V]),
        .pass   (cond_pass)
    );

    // Lane mask keeps a single-lane build from selecting a nonexistent lane.
    assign lane_in  = addr_in[LANE_W-1:0] & LANE_W'(BE_W - 1);
    assign lane_q   = addr_q[LANE_W-1:0] & LANE_W'(BE_W - 1);
    assign byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
    assign accept   = ~rst & op_valid & cond_pass & (op_load | op_store) & (state_q == ST_IDLE);

`ifdef MEM_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = ~op_byte & (lane_in != '0);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        we_d    = we_q;
        load_d  = load_q;
        byte_d  = byte_q;
        rd_d    = rd_q;
        rdata_d = rdata_q;
        fault_d = 1'b0;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    stall   = 1'b1;
                    cnt_d   = '0;
                    addr_d  = op_byte ? addr_in : (addr_in & ~LANE_MASK);
                    be_d    = op_byte ? (BE_W'(1) << lane_in) : '1;
                    wdata_d = op_byte ? {BE_W{store_data[7:0]}} : store_data;
                    we_d    = op_store;
                    load_d  = op_load;
                    byte_d  = op_byte;
                    rd_d    = op_rd;
                    state_d = ST_REQ;
`ifdef MEM_ALIGN_CHECK_EN
                    if (misaligned) begin
                        state_d = ST_RESP;
                        fault_d = 1'b1;
                        load_d  = 1'b0;
                    end
`endif
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                if (mem_ack) begin
                    rdata_d = byte_q ? DATA_W'(byte_sel) : mem_rdata;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    fault_d = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            load_q  <= 1'b0;
            byte_q  <= 1'b0;
            rd_q    <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            load_q  <= load_d;
            byte_q  <= byte_d;
            rd_q    <= rd_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    assign mem_req   = (state_q == ST_REQ);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign wb_valid  = (state_q == ST_RESP) & load_q & ~fault_q;
    assign wb_rd     = rd_q;
    assign wb_data   = rdata_q;
    assign fault     = (state_q == ST_RESP) & fault_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: driver pushes expected requests, a memory responder
// checks them and pushes expected writeback/fault results that a monitor pops and compares.
module tb_mem_access_ctrl;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid, op_load, op_store, op_byte;
    logic [3:0]  op_cond, op_rd;
    logic [31:0] status_reg, addr_in, store_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall, wb_valid, fault;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    mem_access_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_load(op_load), .op_store(op_store),
        .op_byte(op_byte), .op_cond(op_cond), .op_rd(op_rd), .status_reg(status_reg),
        .addr_in(addr_in), .store_data(store_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .fault(fault)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        load;
        logic        byte_m;
        logic [3:0]  rd;
    } req_t;

    typedef struct {
        logic        is_fault;
        logic [3:0]  rd;
        logic [31:0] data;
    } res_t;

    req_t        req_q[$];
    res_t        res_q[$];
    int          ack_plan[$];
    logic [31:0] rdata_plan[$];
    bit          resp_en   = 1'b1;
    bit          stray_ack = 1'b0;
    int          checks    = 0;
    int          failures  = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ARM condition table written straight from the flag equations; f = {N,Z,C,V}.
    function automatic bit cond_ok(logic [3:0] c, logic [3:0] f);
        bit n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // ack_at: REQ cycle (1-based) in which the memory acks; > MAX_WAIT means never.
    task automatic issue(bit vld, bit ld, bit st, bit byt, logic [3:0] cond, logic [3:0] nzcv,
                         logic [31:0] addr, logic [31:0] sd, logic [3:0] rd,
                         int ack_at, logic [31:0] rdata);
        bit   acc, issue_req;
        req_t r;
        res_t e;
        int   guard;
        @(negedge clk);
        op_valid   = vld;
        op_load    = ld;
        op_store   = st;
        op_byte    = byt;
        op_cond    = cond;
        op_rd      = rd;
        status_reg = {nzcv, 28'($urandom)};
        addr_in    = addr;
        store_data = sd;
        acc        = vld && (ld || st) && cond_ok(cond, nzcv);
        issue_req  = acc;
`ifdef MEM_ALIGN_CHECK_EN
        if (!byt && addr[1:0] != 2'b00) issue_req = 1'b0;
`endif
        if (acc && !issue_req) begin
            e.is_fault = 1'b1; e.rd = 4'h0; e.data = 32'h0;
            res_q.push_back(e);
        end
        if (issue_req) begin
            r.addr   = byt ? addr : {addr[31:2], 2'b00};
            r.be     = byt ? (4'b0001 << addr[1:0]) : 4'hF;
            r.wdata  = byt ? {4{sd[7:0]}} : sd;
            r.we     = st;
            r.load   = ld;
            r.byte_m = byt;
            r.rd     = rd;
            req_q.push_back(r);
            ack_plan.push_back(ack_at);
            rdata_plan.push_back(rdata);
        end
        #1;
        check("accept_stall", stall, acc);
        guard = 0;
        while (stall && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 100) check("stall_timeout", stall, 0);
    endtask

    task automatic serve();
        req_t        exp;
        res_t        e;
        int          ack_at;
        logic [31:0] rv;
        bit          acked;
        acked = 1'b0;
        if (req_q.size() == 0) begin
            check("unexpected_req", mem_req, 0);
            return;
        end
        exp    = req_q.pop_front();
        ack_at = ack_plan.pop_front();
        rv     = rdata_plan.pop_front();
        check("req_addr", mem_addr, exp.addr);
        check("req_we", mem_we, exp.we);
        check("req_be", mem_be, exp.be);
        check("req_wdata", mem_wdata, exp.wdata);
        for (int n = 1; n <= MAX_WAIT; n++) begin
            if (n > 1) begin
                @(negedge clk);
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
            check("req_held", mem_req, 1);
            check("req_stall", stall, 1);
            if (n == ack_at) begin
                mem_ack   = 1'b1;
                mem_rdata = rv;
                acked     = 1'b1;
                break;
            end
        end
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        check("resp_req_low", mem_req, 0);
        check("resp_stall", stall, 0);
        check("resp_fault", fault, !acked);
        check("resp_wb_valid", wb_valid, acked && exp.load);
        if (!acked) begin
            e.is_fault = 1'b1; e.rd = 4'h0; e.data = 32'h0;
            res_q.push_back(e);
        end else if (exp.load) begin
            e.is_fault = 1'b0;
            e.rd       = exp.rd;
            e.data     = exp.byte_m ? ((rv >> (8 * exp.addr[1:0])) & 32'hFF) : rv;
            res_q.push_back(e);
        end
    endtask

    // Memory model: acks on the planned cycle; occasionally acks with no request outstanding.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_rdata = $urandom;
            if (!resp_en) begin
                mem_ack = stray_ack;
                continue;
            end
            mem_ack = 1'b0;
            if (!rst && mem_req) serve();
            else if (!rst && $urandom_range(0, 7) == 0) mem_ack = 1'b1;
        end
    end

    initial begin : monitor
        res_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && (wb_valid || fault)) begin
                if (res_q.size() == 0) begin
                    check("unexpected_output", {wb_valid, fault}, 2'b00);
                end else begin
                    e = res_q.pop_front();
                    check("out_fault", fault, e.is_fault);
                    check("out_wb_valid", wb_valid, !e.is_fault);
                    if (!e.is_fault) begin
                        check("out_wb_rd", wb_rd, e.rd);
                        check("out_wb_data", wb_data, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_load = 1'b0; op_store = 1'b0; op_byte = 1'b0;
        op_cond = 4'hE; op_rd = 4'h0; status_reg = 32'h0; addr_in = 32'h0; store_data = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_stall", stall, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_fault", fault, 0);
        rst = 1'b0;

        // Directed cases from the access scenarios.
        issue(1, 1, 0, 0, 4'hE, 4'h0, 32'h100, 32'h0, 4'd7, 3, 32'hDEADBEEF);
        issue(1, 0, 1, 1, 4'hE, 4'h0, 32'h103, 32'h5A, 4'd2, 2, 32'h0);
        issue(1, 1, 0, 0, 4'h0, 4'h0, 32'h200, 32'h0, 4'd3, 1, 32'h11111111);
        issue(1, 1, 0, 0, 4'h0, 4'h4, 32'h200, 32'h0, 4'd3, 1, 32'h22222222);
        issue(1, 1, 0, 0, 4'hE, 4'h0, 32'h300, 32'h0, 4'd4, MAX_WAIT + 1, 32'h0);
        issue(1, 1, 0, 0, 4'hE, 4'h0, 32'h304, 32'h0, 4'd5, MAX_WAIT, 32'hCAFEF00D);
        issue(1, 1, 0, 0, 4'hE, 4'h0, 32'h102, 32'h0, 4'd6, 1, 32'h12345678);
        issue(1, 1, 0, 1, 4'hE, 4'h0, 32'h101, 32'h0, 4'd9, 1, 32'hA1B2C3D4);
        issue(1, 1, 0, 0, 4'hF, 4'hF, 32'h400, 32'h0, 4'd1, 1, 32'h0);

        for (int i = 0; i < 300; i++) begin
            int kind, ack_at;
            kind   = $urandom_range(0, 2);
            ack_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, MAX_WAIT + 1)
                                                 : $urandom_range(1, 3);
            issue(($urandom_range(0, 7) != 0), (kind == 0), (kind == 1), 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hE, 4'($urandom),
                  $urandom, $urandom, 4'($urandom), ack_at, $urandom);
        end
        @(negedge clk);
        op_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("req_q_empty", req_q.size(), 0);
        check("res_q_empty", res_q.size(), 0);

        // Reset in the middle of an access, then a late ack that must be ignored.
        resp_en = 1'b0;
        @(negedge clk);
        op_valid = 1'b1; op_load = 1'b1; op_store = 1'b0; op_byte = 1'b0;
        op_cond = 4'hE; op_rd = 4'd8; addr_in = 32'h500;
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        check("midrst_req_before", mem_req, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_req_after", mem_req, 0);
        check("midrst_stall_after", stall, 0);
        rst = 1'b0;
        @(posedge clk);
        stray_ack = 1'b1;
        @(posedge clk);
        stray_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("midrst_no_wb", wb_valid, 0);
            check("midrst_no_req", mem_req, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
